// File: rtl/bv_cfg_pkg.sv
// Shared definitions for the bit-vector RAM configuration loader:
// FSM state encoding, config header layout and bank bus widths.
package bv_cfg_pkg;

   localparam int SEL_W  = 5;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 32;

   localparam logic [7:0] HDR_MAGIC_DEF = 8'hB5;

   localparam int HDR_MAGIC_LSB = 24;
   localparam int HDR_MAGIC_W   = 8;
   localparam int HDR_RSVD_W    = 7;
   localparam int HDR_CNT_LSB   = 11;
   localparam int HDR_CNT_W     = 6;
   localparam int HDR_ADDR_LSB  = 5;
   localparam int HDR_ADDR_W    = 6;
   localparam int HDR_SEL_LSB   = 0;
   localparam int HDR_SEL_W     = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_SKIP = 2'd2
   } cfg_state_e;

   // Field order matches the bit positions above, MSB first.
   typedef struct packed {
      logic [HDR_MAGIC_W-1:0] magic;
      logic [HDR_RSVD_W-1:0]  rsvd;
      logic [HDR_CNT_W-1:0]   cnt_m1;
      logic [HDR_ADDR_W-1:0]  addr;
      logic [HDR_SEL_W-1:0]   sel;
   } cfg_hdr_t;

endpackage

// File: rtl/bv_cfg_loader_if.sv
// Config ingress stream plus the shared bv_ram write bus.
// slave = loader side, master = host/bank side.
interface bv_cfg_loader_if;
   import bv_cfg_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              wr_en;
   logic [SEL_W-1:0]  sram_sel;
   logic [ADDR_W-1:0] addr_wr;
   logic [DATA_W-1:0] din;

   modport master (
      output s_valid, s_data,
      input  s_ready, wr_en, sram_sel, addr_wr, din
   );

   modport slave (
      input  s_valid, s_data,
      output s_ready, wr_en, sram_sel, addr_wr, din
   );

endinterface

// File: rtl/bv_cfg_hdr_dec.sv
// Combinational config header decode: field extraction, magic check and
// bank range check (the range result is only acted on with BV_CFG_RANGE_CHECK_EN).
module bv_cfg_hdr_dec
   import bv_cfg_pkg::*;
#(
   parameter int         NUM_RAMS   = 32,
   parameter int         DATA_DEPTH = 48,
   parameter logic [7:0] HDR_MAGIC  = HDR_MAGIC_DEF
) (
   input  logic [DATA_W-1:0] i_word,
   output logic [SEL_W-1:0]  o_sel,
   output logic [ADDR_W-1:0] o_addr,
   output logic [ADDR_W-1:0] o_cnt_m1,
   output logic              o_magic_ok,
   output logic              o_rng_ok
);

   cfg_hdr_t   w_hdr;
   logic [7:0] w_end;
   logic       w_unused_rsvd;

   assign w_hdr         = cfg_hdr_t'(i_word);
   assign w_unused_rsvd = ^w_hdr.rsvd;

   assign o_sel    = w_hdr.sel;
   assign o_addr   = w_hdr.addr;
   assign o_cnt_m1 = w_hdr.cnt_m1;

   assign o_magic_ok = (w_hdr.magic == HDR_MAGIC);

   // One past the last address touched; needs 7 bits since count reaches 64.
   assign w_end    = 8'(w_hdr.addr) + 8'(w_hdr.cnt_m1) + 8'd1;
   assign o_rng_ok = (32'(w_hdr.sel) < NUM_RAMS) && (32'(w_end) <= DATA_DEPTH);

endmodule

// File: rtl/bv_cfg_loader.sv
// Config sequencer: parses header+payload bursts and drives the bv_ram bank
// write bus. Optional BV_CFG_RANGE_CHECK_EN rejects out-of-range headers and drains them.
module bv_cfg_loader
   import bv_cfg_pkg::*;
#(
   parameter int         NUM_RAMS   = 32,
   parameter int         DATA_DEPTH = 48,
   parameter logic [7:0] HDR_MAGIC  = HDR_MAGIC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   bv_cfg_loader_if.slave      bus,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [NUM_RAMS-1:0] loaded
);

   cfg_state_e        r_state;
   logic              r_ready;
   logic [SEL_W-1:0]  r_sel;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_rem;
   logic              r_wr_en;
   logic [SEL_W-1:0]  r_sram_sel;
   logic [ADDR_W-1:0] r_addr_wr;
   logic [DATA_W-1:0] r_din;
   logic              r_done;
   logic              r_err;
   logic [NUM_RAMS-1:0] r_loaded;

   logic              w_hs;
   logic [SEL_W-1:0]  w_sel;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] w_cnt_m1;
   logic              w_magic_ok;
   logic              w_rng_ok;

   bv_cfg_hdr_dec #(
      .NUM_RAMS   (NUM_RAMS),
      .DATA_DEPTH (DATA_DEPTH),
      .HDR_MAGIC  (HDR_MAGIC)
   ) u_hdr_dec (
      .i_word     (bus.s_data),
      .o_sel      (w_sel),
      .o_addr     (w_addr),
      .o_cnt_m1   (w_cnt_m1),
      .o_magic_ok (w_magic_ok),
      .o_rng_ok   (w_rng_ok)
   );

`ifndef BV_CFG_RANGE_CHECK_EN
   logic w_unused_rng;
   assign w_unused_rng = w_rng_ok;
`endif

   // Every live state accepts; r_ready only masks the reset cycle.
   assign w_hs        = bus.s_valid & r_ready;
   assign bus.s_ready = r_ready;

   assign bus.wr_en    = r_wr_en;
   assign bus.sram_sel = r_sram_sel;
   assign bus.addr_wr  = r_addr_wr;
   assign bus.din      = r_din;

   assign busy   = (r_state != ST_IDLE);
   assign done   = r_done;
   assign err    = r_err;
   assign loaded = r_loaded;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ready    <= 1'b0;
         r_sel      <= '0;
         r_addr     <= '0;
         r_rem      <= '0;
         r_wr_en    <= 1'b0;
         r_sram_sel <= '0;
         r_addr_wr  <= '0;
         r_din      <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_loaded   <= '0;
      end else begin
         r_ready <= 1'b1;
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  if (!w_magic_ok) begin
                     r_err <= 1'b1;
                  end
`ifdef BV_CFG_RANGE_CHECK_EN
                  else if (!w_rng_ok) begin
                     r_err   <= 1'b1;
                     r_rem   <= w_cnt_m1;
                     r_state <= ST_SKIP;
                  end
`endif
                  else begin
                     r_sel   <= w_sel;
                     r_addr  <= w_addr;
                     r_rem   <= w_cnt_m1;
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (w_hs) begin
                  r_wr_en    <= 1'b1;
                  r_sram_sel <= r_sel;
                  r_addr_wr  <= r_addr;
                  r_din      <= bus.s_data;
                  r_addr     <= r_addr + ADDR_W'(1);
                  r_rem      <= r_rem - ADDR_W'(1);
                  if (r_rem == '0) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                     // Indices past NUM_RAMS have no flag to set.
                     for (int i = 0; i < NUM_RAMS; i++) begin
                        if (r_sel == SEL_W'(i)) r_loaded[i] <= 1'b1;
                     end
                  end
               end
            end
`ifdef BV_CFG_RANGE_CHECK_EN
            ST_SKIP: begin
               if (w_hs) begin
                  r_rem <= r_rem - ADDR_W'(1);
                  if (r_rem == '0) r_state <= ST_IDLE;
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bv_cfg_loader.sv
// Scoreboard bench for bv_cfg_loader: stimulus pushes expected writes/done/err
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_bv_cfg_loader;

   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          busy, done, err;
   logic [NR-1:0] loaded;

   bv_cfg_loader_if bus_if();

   bv_cfg_loader #(
      .NUM_RAMS   (NR),
      .DATA_DEPTH (48),
      .HDR_MAGIC  (8'hB5)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus_if),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .loaded (loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  sel;
      logic [5:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [4:0] sel;
      int         cyc;
   } ev_t;

   wr_t wr_q[$];
   ev_t done_q[$];
   int  err_q[$];
   int  n_chk = 0;
   int  n_err = 0;
   int  cyc   = 0;
   wr_t mon_wr;
   ev_t mon_ev;
   int  mon_ecyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_hdr(input logic [7:0] m, input logic [5:0] cm1,
                                          input logic [5:0] a, input logic [4:0] s);
      return {m, 7'd0, cm1, a, s};
   endfunction

   // Monitor: every bus event must match the head of its queue, in the right cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_if.wr_en) begin
            if (wr_q.size() == 0) begin
               chk("wr_unexpected", 64'(bus_if.wr_en), 64'd0);
            end else begin
               mon_wr = wr_q.pop_front();
               chk("wr_sel",  64'(bus_if.sram_sel), 64'(mon_wr.sel));
               chk("wr_addr", 64'(bus_if.addr_wr),  64'(mon_wr.addr));
               chk("wr_din",  64'(bus_if.din),      64'(mon_wr.data));
               chk("wr_cyc",  64'(cyc),             64'(mon_wr.cyc));
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               chk("done_unexpected", 64'(done), 64'd0);
            end else begin
               mon_ev = done_q.pop_front();
               chk("done_cyc",    64'(cyc),                 64'(mon_ev.cyc));
               chk("done_loaded", 64'(loaded[mon_ev.sel]),  64'd1);
               chk("done_busy",   64'(busy),                64'd0);
            end
         end
         if (err) begin
            if (err_q.size() == 0) begin
               chk("err_unexpected", 64'(err), 64'd0);
            end else begin
               mon_ecyc = err_q.pop_front();
               chk("err_cyc", 64'(cyc), 64'(mon_ecyc));
            end
         end
      end
   end

   task automatic offer(input logic [31:0] w, output int h);
      int t = 0;
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = w;
      while (!bus_if.s_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("s_ready_wait", 64'(bus_if.s_ready), 64'd1);
      h = cyc + 1;
   endtask

   task automatic step();
      @(negedge clk);
      bus_if.s_valid = 1'b0;
   endtask

   task automatic push_wr(input logic [4:0] s, input logic [5:0] a, input logic [31:0] d,
                          input int h);
      wr_t e;
      e.sel = s; e.addr = a; e.data = d; e.cyc = h;
      wr_q.push_back(e);
   endtask

   task automatic burst(input logic [4:0] sel, input logic [5:0] a0, input int n,
                        input logic [31:0] base, input int gap_at, input int gap_len,
                        output int hl);
      int  h;
      ev_t d;
      offer(mk_hdr(8'hB5, 6'(n - 1), a0, sel), h);
      step();
      chk("busy_after_hdr", 64'(busy), 64'd1);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            repeat (gap_len) @(negedge clk);
            chk("busy_in_stall", 64'(busy), 64'd1);
         end
         offer(base + 32'(i), h);
         push_wr(sel, a0 + 6'(i), base + 32'(i), h);
         if (i == n - 1) begin
            d.sel = sel;
            d.cyc = h;
            done_q.push_back(d);
         end
         step();
      end
      hl = h;
   endtask

   initial begin
      int  h;
      int  hl;
      ev_t d;
      bus_if.s_valid = 1'b0;
      bus_if.s_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_wr_en",   64'(bus_if.wr_en),    64'd0);
      chk("rst_sel",     64'(bus_if.sram_sel), 64'd0);
      chk("rst_addr",    64'(bus_if.addr_wr),  64'd0);
      chk("rst_din",     64'(bus_if.din),      64'd0);
      chk("rst_busy",    64'(busy),            64'd0);
      chk("rst_done",    64'(done),            64'd0);
      chk("rst_err",     64'(err),             64'd0);
      chk("rst_loaded",  64'(loaded),          64'd0);
      chk("rst_s_ready", 64'(bus_if.s_ready),  64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("s_ready_after_rst", 64'(bus_if.s_ready), 64'd1);

      // RAM 7, addr 4..7, data A0..A3 back-to-back
      burst(5'd7, 6'd4, 4, 32'h0000_00A0, -1, 0, hl);
      chk("loaded_single", 64'(loaded), 64'h80);

      // bad magic: err only, then the next word is a header again
      offer(32'h0000_0000, h);
      err_q.push_back(h);
      step();
      chk("busy_bad_magic", 64'(busy), 64'd0);
      burst(5'd1, 6'd0, 2, 32'h0000_0011, -1, 0, hl);
      chk("loaded_after_bad", 64'(loaded), 64'h82);

      // stall for 3 cycles after 2 words, then a zero-bubble single-word burst
      burst(5'd5, 6'd20, 4, 32'h0000_0050, 2, 3, hl);
      offer(mk_hdr(8'hB5, 6'd0, 6'd0, 5'd6), h);
      chk("zero_bubble", 64'(h), 64'(hl + 1));
      step();
      offer(32'h0000_0066, h);
      push_wr(5'd6, 6'd0, 32'h0000_0066, h);
      d.sel = 5'd6;
      d.cyc = h;
      done_q.push_back(d);
      step();
      chk("loaded_b2b", 64'(loaded), 64'hE2);

`ifdef BV_CFG_RANGE_CHECK_EN
      // RAM 3, addr 46, count 4 overruns depth 48: drained, nothing written
      offer(mk_hdr(8'hB5, 6'd3, 6'd46, 5'd3), h);
      err_q.push_back(h);
      step();
      chk("busy_skip", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) begin
         offer(32'h0000_00C0 + 32'(i), h);
         step();
      end
      chk("busy_after_skip", 64'(busy), 64'd0);
      chk("loaded3_skip", 64'(loaded[3]), 64'd0);
      burst(5'd3, 6'd40, 2, 32'h0000_0030, -1, 0, hl);
      chk("loaded_after_skip", 64'(loaded), 64'hEA);
`else
      // addr 62, count 4 wraps: 62, 63, 0, 1
      burst(5'd9, 6'd62, 4, 32'h0000_0090, -1, 0, hl);
      chk("loaded_wrap", 64'(loaded), 64'h2E2);
`endif

      // reset after 2 of 5 words, with a word pending during the reset edge
      offer(mk_hdr(8'hB5, 6'd4, 6'd10, 5'd2), h);
      step();
      for (int i = 0; i < 2; i++) begin
         offer(32'h0000_0020 + 32'(i), h);
         push_wr(5'd2, 6'd10 + 6'(i), 32'h0000_0020 + 32'(i), h);
         step();
      end
      @(negedge clk);
      bus_if.s_valid = 1'b1;
      bus_if.s_data  = 32'h0000_DEAD;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_wr_en",  64'(bus_if.wr_en),   64'd0);
      chk("mid_rst_busy",   64'(busy),           64'd0);
      chk("mid_rst_loaded", 64'(loaded),         64'd0);
      chk("mid_rst_ready",  64'(bus_if.s_ready), 64'd0);
      bus_if.s_valid = 1'b0;
      rst = 1'b0;
      burst(5'd4, 6'd0, 2, 32'h0000_0040, -1, 0, hl);
      chk("loaded_after_rst", 64'(loaded), 64'h10);

      repeat (3) @(negedge clk);
      chk("wr_q_drained",   64'(wr_q.size()),   64'd0);
      chk("done_q_drained", 64'(done_q.size()), 64'd0);
      chk("err_q_drained",  64'(err_q.size()),  64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
